qbuff_ctrl: RTL and testbench
=============================

Name: qbuff_ctrl

Overview:
Run controller for the time-tag capture buffer. It drives the buffer's start for a programmed capture window and counts the memory writes it produces. It then flushes the buffer pipeline and reads the captured words back out of the capture memory as one AXI4-Stream packet. The block sits between the AXI-Lite register bank and the qbuff/memory pair, and owns the memory read port.

Parameters:
N, 4, capture memory address width; depth is 2^N words.
B, 8, sample width per lane.
L, 4, number of lanes; word width is L*B.
TW, 32, width of the window timer.
DRAIN_CYC, 8, number of cycles start is held low after capture, to flush in-flight buffer writes.

Ports:
aclk  in  1  clock.
aresetn  in  1  reset.
start  out  1  capture enable to the buffer.
mem_we_in  in  1  write strobe snooped from the buffer memory port.
mem_rd_addr  out  N  capture memory read address.
mem_rd_data  in  L*B  read data; valid 1 cycle after mem_rd_addr.
m_axis_tdata  out  L*B  readout data.
m_axis_tvalid  out  1  readout valid.
m_axis_tready  in  1  readout ready.
m_axis_tlast  out  1  last word of the packet.
RUN_REG  in  1  single-cycle run request.
ABORT_REG  in  1  single-cycle abort request.
WINDOW_REG  in  TW  capture window length in cycles.
MAXWR_REG  in  N+1  write budget; 0 means 2^N.
busy  out  1  high in every state except IDLE and DONE.
done  out  1  sticky completion flag.
ovf  out  1  sticky flag: a write was seen after the budget or after memory full.
nwords  out  N+1  number of words captured.

Behaviour:
- Reset: aresetn is synchronous and active-low; clock is aclk.
  - On reset, all outputs go to 0 and the FSM goes to IDLE.
  - Reset mid-operation abandons any packet in progress, with tvalid low on the next cycle.
- FSM states: IDLE, CAPTURE, DRAIN, READ, DONE.
- IDLE:
  - RUN_REG=1 clears done, ovf, nwords and the timer, then goes to CAPTURE.
  - start=1 from the first cycle after the RUN_REG cycle.
- CAPTURE:
  - start=1. The timer counts cycles in CAPTURE.
  - Exit to DRAIN when any of these holds:
    - timer reaches max(WINDOW_REG,1), giving exactly that many start-high cycles;
    - write count reaches the budget;
    - ABORT_REG=1.
  - start=0 from the first DRAIN cycle.
- DRAIN:
  - start=0 for exactly DRAIN_CYC cycles.
  - mem_we_in is still counted during DRAIN.
  - Then go to READ if nwords>0, else to DONE. No packet is emitted when nwords=0.
- Write counting (CAPTURE and DRAIN only):
  - nwords increments on each mem_we_in.
  - nwords saturates at min(budget, 2^N).
  - A mem_we_in arriving while nwords is already saturated sets ovf and does not increment.
  - mem_we_in outside CAPTURE/DRAIN is ignored.
- READ:
  - Reads addresses 0..nwords-1 in order.
  - The 1-cycle memory latency is absorbed by a 2-entry skid buffer. This gives full throughput: 1 beat/cycle while tready=1.
  - Data, tvalid and tlast are held stable while tvalid=1 and tready=0.
  - tlast=1 only on the beat with address nwords-1.
  - Once tlast is accepted, go to DONE.
  - ABORT_REG is ignored in READ, so packets always complete.
  - Address never exceeds nwords-1; no wrap.
- DONE:
  - done=1 and busy=0.
  - RUN_REG starts a new run directly, with the same clears as from IDLE.
- RUN_REG while busy is ignored.
- ABORT_REG in IDLE/DRAIN/DONE is ignored.
- Same-cycle events:
  - Timer expiry together with the final budget write: that write is counted, ovf stays 0, and the FSM goes to DRAIN.
  - RUN_REG and ABORT_REG together in IDLE: the run starts and the abort is ignored.

Decomposition:
- Package qbuff_ctrl_pkg holds:
  - the state enum (IDLE, CAPTURE, DRAIN, READ, DONE);
  - localparam DEPTH = 2^N;
  - a function that returns the effective budget (0 maps to DEPTH).
- One sub-module, rd_skid: a 2-entry AXIS skid buffer that turns the 1-cycle-latency memory read into valid/ready.
  - It exposes an issue/credit signal so the FSM issues a read address only when a slot is free.

Test Plan:
- Window only: WINDOW_REG=20, MAXWR=0, 5 mem_we pulses in CAPTURE.
  - Required: start high exactly 20 cycles, then low 8 cycles.
  - Required: packet of 5 beats with data from addresses 0..4; tlast on beat 5; done=1, ovf=0, nwords=5.
- Budget stop: MAXWR=3, WINDOW=1000, mem_we every cycle.
  - Required: start drops the cycle after the 3rd write.
  - Required: a 4th write in DRAIN sets ovf=1; nwords=3; 3-beat packet.
- Memory full: N=4, MAXWR=0, 18 writes.
  - Required: nwords=16, ovf=1, 16 beats, tlast on address 15.
- Backpressure: 8-word packet with tready toggling 1,0,0,1 repeating.
  - Required: no data loss or duplication; tdata stable while stalled; exactly 8 handshakes.
- Empty and abort: run with zero writes.
  - Required: done=1 and no tvalid.
  - Abort at CAPTURE cycle 4: start high 4 cycles, then DRAIN.
  - Abort in READ: the full packet still completes.
- Reset and RUN edge cases: reset asserted at beat 2 of 6.
  - Required: tvalid=0 and start=0 next cycle; busy=0.
  - RUN_REG while busy: no effect on state or counters.

Source files
------------

// File: rtl/qbuff_ctrl_pkg.sv
// Shared types and helpers for the capture-buffer run controller.
package qbuff_ctrl_pkg;

    // Run controller states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        DRAIN   = 3'd2,
        READ    = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Default capture memory geometry.
    localparam int N_DEF = 4;
    localparam int DEPTH = 1 << N_DEF;

    // A programmed budget of 0 means "the whole memory".
    function automatic int unsigned eff_budget(input int unsigned maxwr,
                                               input int unsigned depth);
        return (maxwr == 0) ? depth : maxwr;
    endfunction

endpackage

// File: rtl/qbuff_ctrl_rd_skid.sv
// Two-entry skid buffer that turns a 1-cycle-latency memory read into an
// AXI4-Stream source.
//
// Handshake: a beat transfers on a cycle where m_tvalid and m_tready are both
// high. While m_tvalid is high and m_tready is low, m_tdata and m_tlast hold.
// m_tvalid never depends on m_tready.
//
// The owner pulses issue together with the read address; the word lands here
// on the next cycle. can_issue is high only when that word is guaranteed a
// slot, counting both stored and in-flight words and the beat leaving now.
module qbuff_ctrl_rd_skid #(
    parameter int W = 32
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         issue,
    input  logic         issue_last,
    input  logic [W-1:0] rd_data,
    output logic         can_issue,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         m_tlast
);

    logic [W-1:0] data_q [2];
    logic [1:0]   last_q;
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         inflight;
    logic         inflight_last;
    logic         push;
    logic         pop;
    logic [1:0]   used;

    assign m_tvalid = (count != 2'd0);
    assign m_tdata  = data_q[rd_ptr];
    assign m_tlast  = last_q[rd_ptr];

    // Slot accounting: the beat popped this cycle frees its slot immediately,
    // which is what keeps one beat per cycle flowing with only two entries.
    always_comb begin
        push      = inflight;
        pop       = m_tvalid && m_tready;
        used      = count + {1'b0, inflight} - {1'b0, pop};
        can_issue = (used < 2'd2);
    end

    // Capture returning read data and advance the FIFO pointers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            data_q[0]     <= '0;
            data_q[1]     <= '0;
            last_q        <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue_last;
            if (push) begin
                data_q[wr_ptr] <= rd_data;
                last_q[wr_ptr] <= inflight_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/qbuff_ctrl.sv
// Run controller for the time-tag capture buffer: opens a capture window,
// counts buffer memory writes, drains the buffer pipeline, then streams the
// captured words out as one AXI4-Stream packet.
module qbuff_ctrl
    import qbuff_ctrl_pkg::*;
#(
    parameter int N         = 4,
    parameter int B         = 8,
    parameter int L         = 4,
    parameter int TW        = 32,
    parameter int DRAIN_CYC = 8
) (
    input  logic           aclk,
    input  logic           aresetn,
    output logic           start,
    input  logic           mem_we_in,
    output logic [N-1:0]   mem_rd_addr,
    input  logic [L*B-1:0] mem_rd_data,
    output logic [L*B-1:0] m_axis_tdata,
    output logic           m_axis_tvalid,
    input  logic           m_axis_tready,
    output logic           m_axis_tlast,
    input  logic           RUN_REG,
    input  logic           ABORT_REG,
    input  logic [TW-1:0]  WINDOW_REG,
    input  logic [N:0]     MAXWR_REG,
    output logic           busy,
    output logic           done,
    output logic           ovf,
    output logic [N:0]     nwords,
    output state_t         state_dbg
);

    localparam int         W       = L * B;
    localparam int         DW      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [N:0] DEPTH_W = (N+1)'(1 << N);

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic [TW-1:0] win_eff;
    logic [N:0]    budget;
    logic [N:0]    limit;
    logic [N:0]    nwords_nx;
    logic [N:0]    rd_cnt;
    logic [N:0]    rd_addr_c;
    logic [DW-1:0] drain_cnt;
    logic          run_ok;
    logic          counting;
    logic          sat;
    logic          ovf_set;
    logic          cap_end;
    logic          drain_end;
    logic          issue;
    logic          issue_last;
    logic          can_issue;
    logic          pop;

    // Window, budget and write-count bookkeeping.
    always_comb begin
        win_eff   = (WINDOW_REG == '0) ? TW'(1) : WINDOW_REG;
        budget    = (N+1)'(eff_budget(32'(MAXWR_REG), 32'(1 << N)));
        limit     = (budget > DEPTH_W) ? DEPTH_W : budget;
        timer_inc = timer + TW'(1);
        run_ok    = RUN_REG && ((state == IDLE) || (state == DONE));
        counting  = mem_we_in && ((state == CAPTURE) || (state == DRAIN));
        sat       = (nwords >= limit);
        ovf_set   = counting && sat;
        nwords_nx = nwords + (N+1)'(counting && !sat);
        cap_end   = (timer_inc >= win_eff) || (nwords_nx >= limit) || ABORT_REG;
        drain_end = (drain_cnt == DW'(DRAIN_CYC - 1));
    end

    // Readout address generation; the address is clamped so it never points
    // past the last captured word once every read has been issued.
    always_comb begin
        issue      = (state == READ) && (rd_cnt < nwords) && can_issue;
        issue_last = (rd_cnt == nwords - (N+1)'(1));
        rd_addr_c  = ((rd_cnt < nwords) || (nwords == '0)) ? rd_cnt
                                                             : nwords - (N+1)'(1);
        pop        = m_axis_tvalid && m_axis_tready;
    end

    assign mem_rd_addr = rd_addr_c[N-1:0];

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic and state-decoded outputs.
    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        busy      = 1'b1;
        state_dbg = state;
        unique case (state)
            IDLE, DONE: begin
                busy = 1'b0;
                if (RUN_REG) state_nx = CAPTURE;
            end
            CAPTURE: begin
                start = 1'b1;
                if (cap_end) state_nx = DRAIN;
            end
            DRAIN: begin
                if (drain_end) state_nx = (nwords_nx != '0) ? READ : DONE;
            end
            READ: begin
                if (pop && m_axis_tlast) state_nx = DONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Run counters and sticky status flags; a new run clears them together.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            timer     <= '0;
            nwords    <= '0;
            ovf       <= 1'b0;
            done      <= 1'b0;
            rd_cnt    <= '0;
            drain_cnt <= '0;
        end else begin
            if (run_ok) begin
                timer  <= '0;
                nwords <= '0;
                ovf    <= 1'b0;
                done   <= 1'b0;
                rd_cnt <= '0;
            end else begin
                if (state == CAPTURE) timer <= timer_inc;
                nwords <= nwords_nx;
                if (ovf_set) ovf <= 1'b1;
                if (state_nx == DONE) done <= 1'b1;
                if (issue) rd_cnt <= rd_cnt + (N+1)'(1);
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
        end
    end

    qbuff_ctrl_rd_skid #(
        .W (W)
    ) u_rd_skid (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .issue      (issue),
        .issue_last (issue_last),
        .rd_data    (mem_rd_data),
        .can_issue  (can_issue),
        .m_tdata    (m_axis_tdata),
        .m_tvalid   (m_axis_tvalid),
        .m_tready   (m_axis_tready),
        .m_tlast    (m_axis_tlast)
    );

endmodule

// File: tb/tb_qbuff_ctrl.sv
// Directed bench for qbuff_ctrl: a behavioural capture memory, a stream
// monitor backed by an expected-beat queue, and per-run status checks.
module tb_qbuff_ctrl;
    import qbuff_ctrl_pkg::*;

    localparam int N         = 4;
    localparam int B         = 8;
    localparam int L         = 4;
    localparam int TW        = 32;
    localparam int DRAIN_CYC = 8;
    localparam int W         = L * B;
    localparam int EW        = W + 1;
    localparam int TMO       = 3000;

    logic          aclk;
    logic          aresetn;
    logic          start;
    logic          mem_we_in;
    logic [N-1:0]  mem_rd_addr;
    logic [W-1:0]  mem_rd_data;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          RUN_REG;
    logic          ABORT_REG;
    logic [TW-1:0] WINDOW_REG;
    logic [N:0]    MAXWR_REG;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [N:0]    nwords;
    state_t        state_dbg;

    qbuff_ctrl #(
        .N(N), .B(B), .L(L), .TW(TW), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .mem_we_in     (mem_we_in),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .RUN_REG       (RUN_REG),
        .ABORT_REG     (ABORT_REG),
        .WINDOW_REG    (WINDOW_REG),
        .MAXWR_REG     (MAXWR_REG),
        .busy          (busy),
        .done          (done),
        .ovf           (ovf),
        .nwords        (nwords),
        .state_dbg     (state_dbg)
    );

    // Clock and capture memory model (1-cycle read latency).
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic [W-1:0] mem [16];
    always @(posedge aclk) mem_rd_data <= mem[mem_rd_addr];

    // Scoreboard and bookkeeping.
    logic [EW-1:0] exp_q [$];
    int            n_total = 0;
    int            n_pass  = 0;
    int            exp_n;
    int            exp_start;
    logic          exp_ovf;
    int            start_cnt;
    int            drain_cnt;
    int            start_in_drain;
    int            tvalid_cnt;
    int            beat_cnt;
    logic          prev_stall;
    logic [EW-1:0] prev_beat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Stream monitor and per-cycle counters, sampled on the falling edge.
    initial begin
        logic [EW-1:0] e;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (start) start_cnt++;
                if (state_dbg == DRAIN) begin
                    drain_cnt++;
                    if (start) start_in_drain++;
                end
                if (m_axis_tvalid) tvalid_cnt++;
                if (prev_stall) begin
                    check("stall_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                          64'({1'b1, prev_beat}));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(e));
                    end
                    beat_cnt++;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat  = {m_axis_tlast, m_axis_tdata};
            end
        end
    end

    // Program a run, fill memory, queue the expected packet, then pulse RUN
    // and drive consecutive write strobes (and an optional capture abort;
    // abort_at < 0 raises ABORT together with RUN).
    task automatic launch(input int window, input int maxwr, input int nwe, input int abort_at);
        int budget;
        int limit;
        budget    = (maxwr == 0) ? 16 : maxwr;
        limit     = (budget < 16) ? budget : 16;
        exp_n     = (nwe < limit) ? nwe : limit;
        exp_ovf   = (nwe > limit);
        exp_start = (window == 0) ? 1 : window;
        if (nwe >= limit && limit < exp_start) exp_start = limit;
        if (abort_at > 0 && abort_at < exp_start) exp_start = abort_at;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int i = 0; i < exp_n; i++) exp_q.push_back({(i == exp_n - 1), mem[i]});
        WINDOW_REG     = TW'(window);
        MAXWR_REG      = (N+1)'(maxwr);
        start_cnt      = 0;
        drain_cnt      = 0;
        start_in_drain = 0;
        tvalid_cnt     = 0;
        beat_cnt       = 0;
        RUN_REG        = 1'b1;
        ABORT_REG      = (abort_at < 0);
        tick();
        RUN_REG   = 1'b0;
        ABORT_REG = 1'b0;
        for (int c = 0; (c < nwe) || (c < abort_at); c++) begin
            mem_we_in = (c < nwe);
            ABORT_REG = (c == abort_at - 1);
            tick();
        end
        mem_we_in = 1'b0;
        ABORT_REG = 1'b0;
    endtask

    // Wait for completion with optional backpressure, abort during readout
    // and a RUN request while busy, then check the run summary.
    task automatic finish_run(input string name, input bit bp, input bit read_abort,
                              input bit run_busy);
        int k;
        bit aborted;
        k       = 0;
        aborted = 1'b0;
        while (!(done === 1'b1) && k < TMO) begin
            m_axis_tready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            RUN_REG       = run_busy && (k == 2);
            ABORT_REG     = read_abort && !aborted && (m_axis_tvalid === 1'b1);
            if (ABORT_REG) aborted = 1'b1;
            tick();
            k++;
        end
        RUN_REG       = 1'b0;
        ABORT_REG     = 1'b0;
        m_axis_tready = 1'b1;
        check({name, "_in_time"},   64'(k < TMO), 64'(1));
        check({name, "_done"},      64'(done), 64'(1));
        check({name, "_busy"},      64'(busy), 64'(0));
        check({name, "_ovf"},       64'(ovf), 64'(exp_ovf));
        check({name, "_nwords"},    64'(nwords), 64'(exp_n));
        check({name, "_start_cyc"}, 64'(start_cnt), 64'(exp_start));
        check({name, "_drain_cyc"}, 64'(drain_cnt), 64'(DRAIN_CYC));
        check({name, "_drain_start"}, 64'(start_in_drain), 64'(0));
        check({name, "_beats"},     64'(beat_cnt), 64'(exp_n));
        check({name, "_q_empty"},   64'(exp_q.size()), 64'(0));
        if (exp_n == 0) check({name, "_no_tvalid"}, 64'(tvalid_cnt), 64'(0));
        if (read_abort) check({name, "_abort_sent"}, 64'(aborted), 64'(1));
    endtask

    // Directed sequence.
    initial begin
        int k;
        aresetn       = 1'b0;
        mem_we_in     = 1'b0;
        m_axis_tready = 1'b1;
        RUN_REG       = 1'b0;
        ABORT_REG     = 1'b0;
        WINDOW_REG    = '0;
        MAXWR_REG     = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) tick();
        check("rst_start",  64'(start), 64'(0));
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_tlast",  64'(m_axis_tlast), 64'(0));
        check("rst_tdata",  64'(m_axis_tdata), 64'(0));
        check("rst_rdaddr", 64'(mem_rd_addr), 64'(0));
        check("rst_busy",   64'(busy), 64'(0));
        check("rst_done",   64'(done), 64'(0));
        check("rst_ovf",    64'(ovf), 64'(0));
        check("rst_nwords", 64'(nwords), 64'(0));
        check("rst_state",  64'(state_dbg), 64'(IDLE));
        aresetn = 1'b1;
        tick();

        launch(20, 0, 5, 0);     finish_run("window", 0, 0, 0);
        launch(1000, 3, 4, 0);   finish_run("budget", 0, 0, 0);
        launch(1000, 0, 18, 0);  finish_run("memfull", 0, 0, 0);
        launch(3, 3, 3, 0);      finish_run("tie", 0, 0, 0);
        launch(30, 0, 8, 0);     finish_run("backpr", 1, 0, 1);
        launch(10, 0, 0, 0);     finish_run("empty", 0, 0, 0);
        launch(1000, 0, 3, 4);   finish_run("cap_abort", 0, 0, 0);
        launch(12, 0, 6, 0);     finish_run("rd_abort", 0, 1, 0);

        // Reset in the middle of a 6-beat packet.
        launch(10, 0, 6, 0);
        k = 0;
        while (beat_cnt < 2 && k < TMO) begin
            tick();
            k++;
        end
        check("midrst_reach", 64'(k < TMO), 64'(1));
        aresetn = 1'b0;
        tick();
        check("midrst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("midrst_start",  64'(start), 64'(0));
        check("midrst_busy",   64'(busy), 64'(0));
        check("midrst_nwords", 64'(nwords), 64'(0));
        check("midrst_state",  64'(state_dbg), 64'(IDLE));
        exp_q.delete();
        aresetn = 1'b1;
        tick();

        // RUN and ABORT together from IDLE, with a zero window.
        launch(0, 0, 1, -1);     finish_run("run_abort", 0, 0, 0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
